// File: rtl/csa_seq_multiplier.sv
// Iterative unsigned multiplier / MAC: carry-save accumulation of
// BITS_PER_CYCLE partial products per cycle, one carry-propagate add at the end.
module csa_seq_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW   = 2 * WIDTH;
    localparam int ITER = (BITS_PER_CYCLE > 0) ? WIDTH / BITS_PER_CYCLE : 1;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    generate
        if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("csa_seq_multiplier: illegal BITS_PER_CYCLE for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PW-1:0]     sum;
    logic [PW-1:0]     carry;
    logic [PW-1:0]     sum_nx;
    logic [PW-1:0]     carry_nx;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     s_t;
    logic [PW-1:0]     c_t;

    // Operands are pre-shifted each cycle, so bit j of mplier and
    // mcand<<j always address group bit g*BITS_PER_CYCLE+j.
    always_comb begin
        sum_nx   = sum;
        carry_nx = carry;
        pp       = '0;
        s_t      = '0;
        c_t      = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            pp       = mplier[j] ? (mcand << j) : '0;
            s_t      = sum_nx ^ carry_nx ^ pp;
            c_t      = ((sum_nx & carry_nx) | (sum_nx & pp) |
                        (carry_nx & pp)) << 1;
            sum_nx   = s_t;
            carry_nx = c_t;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            sum     <= '0;
            carry   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= PW'(a);
                        mplier <= b;
                        sum    <= acc ? product : '0;
                        carry  <= '0;
                        count  <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum    <= sum_nx;
                    carry  <= carry_nx;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    if (count == LAST) begin
                        state <= RESOLVE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESOLVE: begin
                    product <= sum + carry;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);

endmodule
